// File: rtl/tx_line_sel.sv
// tx_line_sel -- registered N-source selector that drives the UART TX line.
//
// Purpose:
//   Picks one of N_SRC line-level sources (idle, start, data, parity, stop,
//   test, ...) and drives it onto tx_out through a register. A selection
//   change only takes effect on a bit_tick, so the line never changes source
//   in the middle of a bit. Requests enter through a one-deep valid/ready
//   slot. Code N_SRC returns the line to idle.
//
// Optional feature (compile-time macro BREAK_GEN_EN):
//   Adds break_req/break_busy and a BREAK state that holds the line at
//   ~IDLE_LEVEL for BREAK_BITS bit times.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   bit_tick    in   one-cycle strobe at each baud bit boundary
//   src         in   [N_SRC-1:0] level sources, src[i] selected by code i
//   sel_code    in   [SEL_W-1:0] requested source code
//   sel_valid   in   request strobe
//   sel_ready   out  pending slot empty (accept on sel_valid && sel_ready)
//   tx_out      out  registered TX line
//   active_sel  out  [SEL_W-1:0] code driving tx_out (N_SRC when idle)
//   sel_err     out  sticky flag: an out-of-range code was accepted
//   break_req   in   (BREAK_GEN_EN) request a line break
//   break_busy  out  (BREAK_GEN_EN) break pending or in progress
module tx_line_sel #(
   parameter int   N_SRC      = 4,
   parameter int   SEL_W      = $clog2(N_SRC + 1),
   parameter logic IDLE_LEVEL = 1'b1
`ifdef BREAK_GEN_EN
   , parameter int BREAK_BITS = 12
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_tick,
   input  logic [N_SRC-1:0] src,
   input  logic [SEL_W-1:0] sel_code,
   input  logic             sel_valid,
   output logic             sel_ready,
   output logic             tx_out,
   output logic [SEL_W-1:0] active_sel,
   output logic             sel_err
`ifdef BREAK_GEN_EN
   , input  logic           break_req,
   output logic             break_busy
`endif
);

   localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(N_SRC);

`ifdef BREAK_GEN_EN
   localparam int CNT_W = $clog2(BREAK_BITS + 1);
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BREAK} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_ACTIVE} state_t;
`endif

   state_t           state, state_nx;
   logic [SEL_W-1:0] act_nx;
   logic [SEL_W-1:0] pend_code, pend_code_nx;
   logic             pend_full, pend_full_nx;
   logic             sel_err_nx;
   logic             tx_nx;
`ifdef BREAK_GEN_EN
   logic             brk_pend, brk_pend_nx;
   logic [CNT_W-1:0] brk_cnt, brk_cnt_nx;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         active_sel <= IDLE_CODE;
         pend_code  <= IDLE_CODE;
         pend_full  <= 1'b0;
         sel_err    <= 1'b0;
         tx_out     <= IDLE_LEVEL;
`ifdef BREAK_GEN_EN
         brk_pend   <= 1'b0;
         brk_cnt    <= '0;
`endif
      end else begin
         state      <= state_nx;
         active_sel <= act_nx;
         pend_code  <= pend_code_nx;
         pend_full  <= pend_full_nx;
         sel_err    <= sel_err_nx;
         tx_out     <= tx_nx;
`ifdef BREAK_GEN_EN
         brk_pend   <= brk_pend_nx;
         brk_cnt    <= brk_cnt_nx;
`endif
      end
   end

   always_comb begin
      state_nx     = state;
      act_nx       = active_sel;
      pend_code_nx = pend_code;
      pend_full_nx = pend_full;
      sel_err_nx   = sel_err;
      tx_nx        = IDLE_LEVEL;
`ifdef BREAK_GEN_EN
      brk_pend_nx  = brk_pend;
      brk_cnt_nx   = brk_cnt;
`endif

      // Accept into the slot. Out-of-range codes are folded to return-to-idle.
      if (sel_valid && !pend_full) begin
         pend_full_nx = 1'b1;
         if (sel_code > IDLE_CODE) begin
            pend_code_nx = IDLE_CODE;
            sel_err_nx   = 1'b1;
         end else begin
            pend_code_nx = sel_code;
         end
      end

      // Apply uses the registered slot, so a request accepted on this very
      // tick waits for the next one.
      if (bit_tick) begin
`ifdef BREAK_GEN_EN
         if (state == S_BREAK) begin
            brk_cnt_nx = brk_cnt - CNT_W'(1);
            if (brk_cnt == CNT_W'(1)) begin
               state_nx = S_IDLE;
               act_nx   = IDLE_CODE;
            end
         end else if (brk_pend) begin
            // Break beats a queued select; the select stays in the slot.
            state_nx    = S_BREAK;
            act_nx      = IDLE_CODE;
            brk_cnt_nx  = CNT_W'(BREAK_BITS);
            brk_pend_nx = 1'b0;
         end else
`endif
         if (pend_full) begin
            act_nx       = pend_code;
            pend_full_nx = 1'b0;
            state_nx     = (pend_code == IDLE_CODE) ? S_IDLE : S_ACTIVE;
         end
      end

`ifdef BREAK_GEN_EN
      if (break_req && !brk_pend && state != S_BREAK)
         brk_pend_nx = 1'b1;
`endif

      // Drive from next-state values so a switching tick shows the new
      // source on the very next cycle.
      if (state_nx == S_ACTIVE) begin
         for (int i = 0; i < N_SRC; i++)
            if (act_nx == SEL_W'(i)) tx_nx = src[i];
      end
`ifdef BREAK_GEN_EN
      if (state_nx == S_BREAK) tx_nx = ~IDLE_LEVEL;
`endif
   end

   assign sel_ready = !pend_full;
`ifdef BREAK_GEN_EN
   assign break_busy = brk_pend || (state == S_BREAK);
`endif

endmodule
